// File: rtl/sub_shift_rows_if.sv
// rtl/sub_shift_rows_if.sv - valid/ready input and output channels of sub_shift_rows
interface sub_shift_rows_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;

  // Producer of in_data and consumer of out_data
  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  // The stage itself
  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/sub_shift_rows.sv
// rtl/sub_shift_rows.sv - iterative AES SubBytes + ShiftRows stage; SUBSHIFT_INV_EN adds inverse mode
module sub_shift_rows #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic clk,
  input  logic rst_n,
`ifdef SUBSHIFT_INV_EN
  input  logic inv,
`endif
  sub_shift_rows_if.slave bus
);

  localparam int N  = 16 / BYTES_PER_CYCLE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Forward S-box, entry 0 in the top byte so entry b sits at bit offset {~b, 3'b000}
  localparam logic [2047:0] SBOX_FWD = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

`ifdef SUBSHIFT_INV_EN
  // Inverse table derived from the forward one at elaboration so the two can never disagree
  function automatic logic [2047:0] build_inv_table();
    logic [2047:0] t;
    logic [7:0]    s;
    t = '0;
    for (int i = 0; i < 256; i++) begin
      s = SBOX_FWD[(255 - i) * 8 +: 8];
      t[{~s, 3'b000} +: 8] = 8'(i);
    end
    return t;
  endfunction

  localparam logic [2047:0] SBOX_INV = build_inv_table();
`endif

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [127:0]    work, work_nxt, sub_work, shifted;
  logic            in_ready, out_valid;
`ifdef SUBSHIFT_INV_EN
  logic            inv_q, inv_nxt;
`endif

  // Replace the BYTES_PER_CYCLE bytes selected by the counter using the shared S-box lanes
  always_comb begin
    int         idx;
    logic [7:0] b;
    sub_work = work;
    idx      = 0;
    b        = '0;
    for (int k = 0; k < BYTES_PER_CYCLE; k++) begin
      idx = 15 - (int'(cnt) * BYTES_PER_CYCLE + k);
      b   = work[idx * 8 +: 8];
`ifdef SUBSHIFT_INV_EN
      sub_work[idx * 8 +: 8] = inv_q ? SBOX_INV[{~b, 3'b000} +: 8] : SBOX_FWD[{~b, 3'b000} +: 8];
`else
      sub_work[idx * 8 +: 8] = SBOX_FWD[{~b, 3'b000} +: 8];
`endif
    end
  end

  // ShiftRows (or InvShiftRows) is pure wiring from the work register to out_data
  always_comb begin
    int src;
    shifted = '0;
    src     = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
`ifdef SUBSHIFT_INV_EN
        src = inv_q ? ((c - r + 4) % 4) : ((c + r) % 4);
`else
        src = (c + r) % 4;
`endif
        shifted[(15 - (c * 4 + r)) * 8 +: 8] = work[(15 - (src * 4 + r)) * 8 +: 8];
      end
    end
  end

  // Next-state and handshake outputs; no new state is taken until the result has left
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    work_nxt  = work;
    in_ready  = 1'b0;
    out_valid = 1'b0;
`ifdef SUBSHIFT_INV_EN
    inv_nxt   = inv_q;
`endif
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          work_nxt  = bus.in_data;
          cnt_nxt   = '0;
          state_nxt = SUB;
`ifdef SUBSHIFT_INV_EN
          inv_nxt   = inv;
`endif
        end
      end
      SUB: begin
        work_nxt = sub_work;
        if (cnt == LAST) begin
          cnt_nxt   = '0;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state, byte counter, work register and captured mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      work  <= '0;
`ifdef SUBSHIFT_INV_EN
      inv_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      work  <= work_nxt;
`ifdef SUBSHIFT_INV_EN
      inv_q <= inv_nxt;
`endif
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = shifted;

endmodule

// File: tb/tb_sub_shift_rows.sv
// tb/tb_sub_shift_rows.sv - self-checking bench for sub_shift_rows at 1, 4 and 16 bytes per cycle
module tb_sub_shift_rows;
  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Index 0: 1 byte/cycle, 1: 4 bytes/cycle, 2: 16 bytes/cycle
  logic         iv [3];
  logic         ordy [3];
  logic         invs [3];
  logic [127:0] idat [3];
  logic         ir [3];
  logic         ov [3];
  logic [127:0] od [3];

  sub_shift_rows_if b1 ();
  sub_shift_rows_if b4 ();
  sub_shift_rows_if b16 ();

  assign b1.in_valid   = iv[0];
  assign b1.in_data    = idat[0];
  assign b1.out_ready  = ordy[0];
  assign ir[0]         = b1.in_ready;
  assign ov[0]         = b1.out_valid;
  assign od[0]         = b1.out_data;
  assign b4.in_valid   = iv[1];
  assign b4.in_data    = idat[1];
  assign b4.out_ready  = ordy[1];
  assign ir[1]         = b4.in_ready;
  assign ov[1]         = b4.out_valid;
  assign od[1]         = b4.out_data;
  assign b16.in_valid  = iv[2];
  assign b16.in_data   = idat[2];
  assign b16.out_ready = ordy[2];
  assign ir[2]         = b16.in_ready;
  assign ov[2]         = b16.out_valid;
  assign od[2]         = b16.out_data;

  sub_shift_rows #(.BYTES_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n),
`ifdef SUBSHIFT_INV_EN
    .inv(invs[0]),
`endif
    .bus(b1));
  sub_shift_rows #(.BYTES_PER_CYCLE(4)) u4 (
    .clk(clk), .rst_n(rst_n),
`ifdef SUBSHIFT_INV_EN
    .inv(invs[1]),
`endif
    .bus(b4));
  sub_shift_rows #(.BYTES_PER_CYCLE(16)) u16 (
    .clk(clk), .rst_n(rst_n),
`ifdef SUBSHIFT_INV_EN
    .inv(invs[2]),
`endif
    .bus(b16));

  // ---------------- reference model (GF(2^8) arithmetic, not tables) ----------------
  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] y, input int n);
    logic [15:0] t;
    t = {y, y} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox_model(input logic [7:0] x);
    logic [7:0] y;
    y = 8'h00;
    for (int v = 1; v < 256; v++) if (gmul(x, 8'(v)) == 8'h01) y = 8'(v);
    return y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model_out(input logic [127:0] d, input logic m);
    logic [7:0]   s [16];
    logic [127:0] o;
    int           src;
    o = '0;
    for (int i = 0; i < 16; i++) s[i] = m ? inv_tab[d[127 - 8 * i -: 8]] : fwd_tab[d[127 - 8 * i -: 8]];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        src = m ? ((c - r + 4) % 4) : ((c + r) % 4);
        o[127 - 8 * (c * 4 + r) -: 8] = s[src * 4 + r];
      end
    return o;
  endfunction

  function automatic logic [127:0] mix_model(input logic [127:0] d);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = d[127 - 8 * (c * 4 + 0) -: 8];
      a1 = d[127 - 8 * (c * 4 + 1) -: 8];
      a2 = d[127 - 8 * (c * 4 + 2) -: 8];
      a3 = d[127 - 8 * (c * 4 + 3) -: 8];
      o[127 - 8 * (c * 4 + 0) -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127 - 8 * (c * 4 + 1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127 - 8 * (c * 4 + 2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127 - 8 * (c * 4 + 3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic int nlat(input int id);
    return (id == 0) ? 16 : ((id == 1) ? 4 : 1);
  endfunction

  // ---------------- comparison helpers ----------------
  task automatic chk_word(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard and per-cycle compare process ----------------
  logic         pending [3];
  logic [127:0] exp_data [3];
  int           rdy_cyc [3];
  int           acc_cnt [3];
  int           done_cnt [3];
  int           acc_log [$];

  task automatic check_inst(input int id);
    logic exp_ov;
    if (!rst_n) begin
      pending[id] = 1'b0;
      chk_int($sformatf("u%0d_reset_in_ready", id), int'(ir[id]), 1);
      chk_int($sformatf("u%0d_reset_out_valid", id), int'(ov[id]), 0);
      chk_word($sformatf("u%0d_reset_out_data", id), od[id], '0);
    end else begin
      exp_ov = pending[id] && (cyc >= rdy_cyc[id]);
      chk_int($sformatf("u%0d_out_valid", id), int'(ov[id]), int'(exp_ov));
      chk_int($sformatf("u%0d_in_ready", id), int'(ir[id]), int'(!pending[id]));
      if (ov[id] && exp_ov) chk_word($sformatf("u%0d_out_data", id), od[id], exp_data[id]);
      if (ir[id] && iv[id]) begin
        pending[id]  = 1'b1;
        exp_data[id] = model_out(idat[id], invs[id]);
        rdy_cyc[id]  = cyc + 1 + nlat(id);
        acc_cnt[id]++;
        if (id == 1) acc_log.push_back(cyc + 1);
      end else if (ov[id] && ordy[id] && pending[id]) begin
        pending[id] = 1'b0;
        done_cnt[id]++;
      end
    end
  endtask

  always @(negedge clk) for (int id = 0; id < 3; id++) check_inst(id);

  // ---------------- stimulus tasks (entered and left just after a rising edge) ----------------
  task automatic send(input int id, input logic [127:0] d, input logic m);
    logic ok;
    ok       = 1'b0;
    iv[id]   = 1'b1;
    idat[id] = d;
    invs[id] = m;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ir[id]) ok = 1'b1;
    end
    if (!ok) chk_int($sformatf("u%0d_accept_timeout", id), 0, 1);
    @(posedge clk);
    #1;
    iv[id] = 1'b0;
  endtask

  task automatic wait_out(input int id, output logic [127:0] got);
    logic ok;
    ok  = 1'b0;
    got = '0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (ov[id]) begin
        ok  = 1'b1;
        got = od[id];
      end
    end
    if (!ok) chk_int($sformatf("u%0d_out_timeout", id), 0, 1);
    @(posedge clk);
    #1;
  endtask

  logic [127:0] fips_in, fips_out, fips_mix, got, cap;
  logic [127:0] vecs [3];
  logic         seen;
  int           acc_before, done_before;

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    fips_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    fips_out = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    fips_mix = 128'h046681e5e0cb199a48f8d37a2806264c;
    vecs[0]  = fips_in;
    vecs[1]  = 128'ha49c7ff2689f352b6b5bea43026a5049;
    vecs[2]  = 128'haa8f5f0361dde3ef82d24ad26832469a;
    for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_model(8'(i));
    for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);
    for (int id = 0; id < 3; id++) begin
      iv[id] = 1'b0; ordy[id] = 1'b1; invs[id] = 1'b0; idat[id] = '0;
      pending[id] = 1'b0; exp_data[id] = '0; rdy_cyc[id] = 0; acc_cnt[id] = 0; done_cnt[id] = 0;
    end
    rst_n = 1'b0;

    // Pin the model against known values
    chk_int("model_sbox_00", int'(fwd_tab[8'h00]), 'h63);
    chk_int("model_sbox_ff", int'(fwd_tab[8'hff]), 'h16);
    chk_int("model_sbox_53", int'(fwd_tab[8'h53]), 'hed);
    chk_word("model_fips_round1", model_out(fips_in, 1'b0), fips_out);
    chk_word("model_fips_mix", mix_model(fips_out), fips_mix);

    repeat (2) @(negedge clk);
    chk_int("reset_in_ready", int'(ir[1]), 1);
    chk_int("reset_out_valid", int'(ov[1]), 0);
    chk_word("reset_out_data", od[1], '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // FIPS-197 App. B round 1 through the default configuration
    send(1, fips_in, 1'b0);
    wait_out(1, got);
    chk_word("fips_round1", got, fips_out);
    chk_word("fips_chain_mix", mix_model(got), fips_mix);

    // All-zero and all-ones states at 1, 4 and 16 bytes per cycle
    for (int id = 0; id < 3; id++) begin
      send(id, '0, 1'b0);
      wait_out(id, got);
      chk_word($sformatf("u%0d_all00", id), got, {16{8'h63}});
      send(id, '1, 1'b0);
      wait_out(id, got);
      chk_word($sformatf("u%0d_allff", id), got, {16{8'h16}});
    end

    // Reset after two SUB cycles aborts the state
    send(1, fips_in, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_int("midsub_reset_out_valid", int'(ov[1]), 0);
    chk_int("midsub_reset_in_ready", int'(ir[1]), 1);
    chk_word("midsub_reset_out_data", od[1], '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      seen = seen | ov[1];
    end
    chk_int("midsub_no_spurious_valid", int'(seen), 0);
    @(posedge clk);
    #1;

    // Backpressure: DONE holds, a stray in_valid is ignored, then exactly one handshake
    ordy[1] = 1'b0;
    send(1, vecs[1], 1'b0);
    wait_out(1, cap);
    chk_word("bp_data", cap, model_out(vecs[1], 1'b0));
    acc_before  = acc_cnt[1];
    done_before = done_cnt[1];
    for (int k = 0; k < 10; k++) begin
      iv[1]   = (k == 3);
      idat[1] = vecs[2];
      @(negedge clk);
      chk_int("bp_out_valid_held", int'(ov[1]), 1);
      chk_word("bp_out_data_held", od[1], cap);
      chk_int("bp_in_ready_low", int'(ir[1]), 0);
      @(posedge clk);
      #1;
    end
    iv[1]   = 1'b0;
    ordy[1] = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_int("bp_release_in_ready", int'(ir[1]), 1);
    chk_int("bp_release_out_valid", int'(ov[1]), 0);
    chk_int("bp_stray_ignored", acc_cnt[1], acc_before);
    chk_int("bp_one_handshake", done_cnt[1], done_before + 1);
    @(posedge clk);
    #1;

    // Throughput: in_valid held high, three states accepted N+2 cycles apart
    acc_log.delete();
    done_before = done_cnt[1];
    iv[1] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idat[1] = vecs[k];
      seen    = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
        @(negedge clk);
        if (ir[1]) seen = 1'b1;
      end
      if (!seen) chk_int("tp_accept_timeout", 0, 1);
      @(posedge clk);
      #1;
    end
    iv[1] = 1'b0;
    repeat (8) @(negedge clk);
    chk_int("tp_accept_count", acc_log.size(), 3);
    if (acc_log.size() == 3) begin
      chk_int("tp_spacing_1", acc_log[1] - acc_log[0], 6);
      chk_int("tp_spacing_2", acc_log[2] - acc_log[1], 6);
    end
    chk_int("tp_outputs", done_cnt[1], done_before + 3);
    @(posedge clk);
    #1;

`ifdef SUBSHIFT_INV_EN
    // Inverse mode, then a forward state with inv toggled during SUB
    send(1, fips_out, 1'b1);
    wait_out(1, got);
    chk_word("inv_round1", got, fips_in);
    send(1, fips_in, 1'b0);
    invs[1] = 1'b1;
    @(posedge clk);
    #1;
    invs[1] = 1'b0;
    wait_out(1, got);
    chk_word("inv_toggle_forward", got, fips_out);
`endif

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sub_shift_rows.md
# sub_shift_rows

Iterative AES SubBytes + ShiftRows stage that sits directly upstream of the MixColumns block and feeds it a 128-bit state. It accepts one state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through shared S-box instances. It then applies ShiftRows and holds the result on a valid/ready output until the consumer takes it. Byte layout is column-major: [127:120] is byte 0 (row 0, col 0), [119:112] is byte 1 (row 1, col 0), ... [7:0] is byte 15 (row 3, col 3).

## Interface
- BYTES_PER_CYCLE, 4, S-box instances and bytes substituted per SUB cycle; legal values 1, 2, 4, 8, 16.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a state.
- in_data  in  128  input state, column-major.
- out_valid  out  1  out_data holds a finished state.
- out_ready  in  1  consumer (MixColumns path) accepts out_data.
- out_data  out  128  ShiftRows(SubBytes(in_data)), column-major.
- inv  in  1  inverse mode. Present only with SUBSHIFT_INV_EN.

## Operation
- Three states.
  - IDLE: in_ready=1. On in_valid & in_ready, load in_data into a 128-bit work register, clear the byte counter, go to SUB. Capture inv at the same edge (with SUBSHIFT_INV_EN).
  - SUB: each cycle, replace BYTES_PER_CYCLE consecutive bytes in place with S-box(byte), starting at byte 0 ([127:120]) and ascending. The counter counts 0..N-1, where N = 16/BYTES_PER_CYCLE. In the cycle where counter = N-1, go to DONE; the counter wraps to 0.
  - DONE: out_valid=1. On out_valid & out_ready, go to IDLE.
- ShiftRows is pure wiring applied to the work register when driving out_data. Row r rotates left by r columns: out byte (r,c) = work byte (r,(c+r) mod 4).
- out_data reflects the work register in every state. It is meaningful only while out_valid=1, and is stable from out_valid rising until the handshake completes.
- in_valid is ignored outside IDLE. in_data need only be stable in the accepting cycle.
- out_ready outside DONE has no effect.
- No back-to-back overlap: in_ready=0 in SUB and DONE, including the DONE cycle where the output is accepted.

## Timing
- Reset (rst_n=0, asynchronous): state=IDLE, in_ready=1, out_valid=0, out_data=128'h0, counter=0. The work register and captured inv are cleared to 0.
- Reset asserted mid-SUB or mid-DONE aborts the state; nothing is output.
- Latency: input accepted at edge T. out_valid rises after edge T+N (N=4 by default, so 4 cycles).
- Throughput: one state per N+2 cycles when out_ready is held high. That is 6 cycles at the default, covering IDLE, N×SUB and DONE.
- Backpressure: DONE holds indefinitely while out_ready=0.
- The S-box is a 256-entry combinational lookup. The only registers are the work register, counter, FSM state and inv.

## Configuration
- SUBSHIFT_INV_EN defined:
  - The inv port exists.
  - inv=1 selects the inverse S-box and InvShiftRows: row r rotates right by r, so out byte (r,c) = work byte (r,(c−r) mod 4).
  - inv=0 gives forward behaviour.
  - Both S-box tables are instantiated and selected per byte by the captured inv.
- SUBSHIFT_INV_EN undefined: there is no inv port, only the forward S-box is instantiated, and the block is forward-only.

## Test plan
- Reset: assert rst_n=0 mid-SUB at BYTES_PER_CYCLE=4 (after 2 SUB cycles) -> in the same cycle out_valid=0, in_ready=1, out_data=0. After release, no spurious out_valid.
- FIPS-197 App. B round 1: in_data=193de3bea0f4e22b9ac68d2ae9f84808 -> after 4 cycles out_data=d4bf5d30e0b452aeb84111f11e2798e5, out_valid=1.
  - Chaining through MixColumns must give 046681e5e0cb199a48f8d37a2806264c.
- Boundary bytes: in_data all 00 -> out_data all 63. in_data all ff -> out_data all 16. Check at BYTES_PER_CYCLE=1 (latency 16), 4 and 16 (latency 1).
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data and out_valid stay constant and in_ready=0. Pulse in_valid during the stall with a new state -> ignored. Raise out_ready -> one handshake, then IDLE.
- Throughput: stream 3 FIPS vectors with out_ready=1 and in_valid always high -> accepts spaced exactly N+2=6 cycles apart, outputs in order and correct.
- With SUBSHIFT_INV_EN: inv=1, in_data=d4bf5d30e0b452aeb84111f11e2798e5 -> out_data=193de3bea0f4e22b9ac68d2ae9f84808.
  - The next state, accepted with inv=0, is processed forward; toggling inv mid-SUB has no effect.
